pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flush, memory-wait freeze.
// Optional PIPE_PERF_CNT_EN adds stall/bubble/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  ID_RS1addr_i,
  input  logic [4:0]  ID_RS2addr_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_RDaddr_i,
  input  logic        ID_BranchTaken_i,
  input  logic        MEM_Req_i,
  input  logic        Mem_Ack_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IFIDFlush_o,
  output logic        IDEXBubble_o,
  output logic        PipeStall_o,
  output logic        MemStart_o,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] StallCycles_o,
  output logic [31:0] BubbleCnt_o,
  output logic [31:0] FlushCnt_o,
`endif
  output logic        Err_o
);

  // state    | meaning
  // IDLE     | held after reset until start_i, pipeline frozen with bubbles
  // RUN      | normal flow, hazard checks active
  // MEM_WAIT | data-memory access outstanding, whole pipeline frozen

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(MEM_TIMEOUT);

  state_t               state;
  logic                 issued;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 err;

  logic load_use;
  logic new_access;
  logic timeout_hit;
  logic advance;

  assign load_use = EX_MemRead_i && (EX_RDaddr_i != 5'd0) &&
                    ((EX_RDaddr_i == ID_RS1addr_i) || (EX_RDaddr_i == ID_RS2addr_i));
  assign new_access  = MEM_Req_i && !issued;
  assign timeout_hit = (wait_cnt == TIMEOUT_MAX) && !Mem_Ack_i;

  always_comb begin
    PCWrite_o    = 1'b0;
    IFIDWrite_o  = 1'b0;
    IFIDFlush_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    PipeStall_o  = 1'b0;
    MemStart_o   = 1'b0;
    advance      = 1'b0;
    case (state)
      IDLE: begin
        PipeStall_o  = 1'b1;
        IDEXBubble_o = 1'b1;
      end
      RUN: begin
        MemStart_o = new_access;
        advance    = !new_access || Mem_Ack_i;
      end
      MEM_WAIT: begin
        advance = (issued && Mem_Ack_i) || timeout_hit;
      end
      default: ;
    endcase
    // Hazard checks also apply in the cycle a memory wait releases.
    if (state != IDLE) begin
      if (!advance) begin
        PipeStall_o = 1'b1;
      end else if (load_use) begin
        IDEXBubble_o = 1'b1;
      end else if (ID_BranchTaken_i) begin
        IFIDFlush_o = 1'b1;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
      end else begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      issued   <= 1'b0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) state <= RUN;
        end
        RUN: begin
          if (new_access && !Mem_Ack_i) begin
            issued   <= 1'b1;
            wait_cnt <= TIMEOUT_W'(1);
            state    <= MEM_WAIT;
          end else begin
            issued <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (Mem_Ack_i) begin
            issued <= 1'b0;
            state  <= RUN;
          end else if (wait_cnt == TIMEOUT_MAX) begin
            err    <= 1'b1;
            issued <= 1'b0;
            state  <= RUN;
          end else begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Err_o = err;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      StallCycles_o <= '0;
      BubbleCnt_o   <= '0;
      FlushCnt_o    <= '0;
    end else if (state != IDLE) begin
      if (!PCWrite_o)   StallCycles_o <= StallCycles_o + 32'd1;
      if (IDEXBubble_o) BubbleCnt_o   <= BubbleCnt_o + 32'd1;
      if (IFIDFlush_o)  FlushCnt_o    <= FlushCnt_o + 32'd1;
    end
  end
`endif

endmodule
